// File: rtl/adc_sample_packer.sv
// adc_sample_packer
//   Write-clock-domain front end of the ADC capture path. Packs p_pack ADC
//   samples into one FIFO word, LSB lane first, and drives the write port of
//   the downstream async FIFO. A start pulse arms a capture of len words.
//   A word that is pending while the FIFO reports full is dropped and counted
//   in ovf_cnt, which saturates at 255. Dropped words still count toward len.
//
//   Optional feature macro: ADC_PACK_HEADER_EN
//     Each accepted start emits a header word, the 16-bit frame count, in the
//     cycle after start. The header is not counted toward len.
//
// Ports
//   wclk       write clock, shared with the FIFO write side
//   wrst_n     asynchronous reset, active-low
//   start      capture request, honoured in IDLE only when len != 0
//   len        capture length in words, latched on an accepted start
//   adc_valid  adc_data is valid this cycle
//   adc_data   ADC sample
//   wfull      FIFO full flag
//   wr         FIFO write strobe (pend & ~wfull)
//   wdata      FIFO write data, held while nothing is pending
//   busy       capture in progress
//   done       one-cycle pulse at the end of a capture
//   ovf_cnt    dropped-word count of the current/last capture
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start with a non-zero len
// CAPTURE | packing samples, presenting words, counting down len
// DONE    | done pulse cycle, returns to IDLE

module adc_sample_packer #(
    parameter int p_nbit_s   = 8,
    parameter int p_pack     = 2,
    parameter int p_nbit_len = 16
) (
    input  logic                         wclk,
    input  logic                         wrst_n,
    input  logic                         start,
    input  logic [p_nbit_len-1:0]        len,
    input  logic                         adc_valid,
    input  logic [p_nbit_s-1:0]          adc_data,
    input  logic                         wfull,
    output logic                         wr,
    output logic [p_nbit_s*p_pack-1:0]   wdata,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   ovf_cnt
);

    localparam int p_nbit_d = p_nbit_s * p_pack;
    localparam int p_nbit_idx = (p_pack > 1) ? $clog2(p_pack) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t                  state;
    logic [p_nbit_idx-1:0]   idx;
    logic [p_nbit_d-1:0]     lanes;
    logic [p_nbit_d-1:0]     word_next;
    logic [p_nbit_len-1:0]   words_left;
    logic                    pend;
    logic                    data_pend;

`ifdef ADC_PACK_HEADER_EN
    logic                    pend_hdr;
    logic [15:0]             frame_cnt;

    assign data_pend = pend & ~pend_hdr;
`else
    assign data_pend = pend;
`endif

    // Never strobe into a full FIFO; the word is dropped instead.
    assign wr = pend & ~wfull;

    // Partial word with the incoming sample merged into the current lane.
    always_comb begin
        word_next = lanes;
        for (int i = 0; i < p_pack; i++) begin
            if (idx == p_nbit_idx'(i)) begin
                word_next[i*p_nbit_s +: p_nbit_s] = adc_data;
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            lanes      <= '0;
            words_left <= '0;
            pend       <= 1'b0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf_cnt    <= '0;
`ifdef ADC_PACK_HEADER_EN
            pend_hdr   <= 1'b0;
            frame_cnt  <= '0;
`endif
        end else begin
            pend <= 1'b0;
            done <= 1'b0;
`ifdef ADC_PACK_HEADER_EN
            pend_hdr <= 1'b0;
`endif
            if (pend && wfull && (ovf_cnt != 8'hFF)) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (start && (len != '0)) begin
                        state      <= ST_CAPTURE;
                        busy       <= 1'b1;
                        words_left <= len;
                        ovf_cnt    <= '0;
                        idx        <= '0;
                        lanes      <= '0;
`ifdef ADC_PACK_HEADER_EN
                        pend       <= 1'b1;
                        pend_hdr   <= 1'b1;
                        wdata      <= p_nbit_d'(frame_cnt);
                        frame_cnt  <= frame_cnt + 16'd1;
`endif
                    end
                end

                ST_CAPTURE: begin
                    // Terminal count: the last word is being presented now.
                    if (data_pend && (words_left == p_nbit_len'(1))) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        if (data_pend) begin
                            words_left <= words_left - p_nbit_len'(1);
                        end
                        if (adc_valid) begin
                            if (idx == p_nbit_idx'(p_pack - 1)) begin
                                wdata <= word_next;
                                pend  <= 1'b1;
                                idx   <= '0;
                            end else begin
                                lanes <= word_next;
                                idx   <= idx + p_nbit_idx'(1);
                            end
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_packer.sv
module tb_adc_sample_packer;

    localparam int SW   = 8;
    localparam int PACK = 2;
    localparam int LW   = 16;
    localparam int DW   = SW * PACK;

    logic          wclk;
    logic          wrst_n;
    logic          start;
    logic [LW-1:0] len;
    logic          adc_valid;
    logic [SW-1:0] adc_data;
    logic          wfull;
    logic          wr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic [7:0]    ovf_cnt;

    adc_sample_packer #(
        .p_nbit_s   (SW),
        .p_pack     (PACK),
        .p_nbit_len (LW)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .start     (start),
        .len       (len),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .wfull     (wfull),
        .wr        (wr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .ovf_cnt   (ovf_cnt)
    );

    typedef struct {
        logic [DW-1:0] w;
        int            c;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [SW-1:0] data_src[$];
    logic [15:0]   fc;
    int            cyc;
    int            n_chk;
    int            n_pass;

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial cyc = 0;
    always @(posedge wclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    // Monitor: every FIFO write must match the next expected word and cycle.
    always @(negedge wclk) begin
        if (wrst_n && wr) begin
            if (sb.size() == 0) begin
                chk("unexpected_wr", wr, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                chk("wdata", wdata, mon_e.w);
                chk("wr_cycle", cyc, mon_e.c);
            end
        end
    end

    // vmode: 0 every cycle, 1 every 3rd cycle, 2 random
    // fmode: 0 never full, 1 always full, 2 full only while word fword pends, 3 random
    task automatic run_capture(input int len_w, input int vmode, input int fmode,
                               input int fword, input bit stress);
        int            k;
        int            words_done;
        int            drops;
        int            j;
        bit            fin;
        bit            v;
        bit            pend_now, pend_next, final_now, final_next;
        int            pidx_now, pidx_next;
        logic [DW-1:0] acc, word_now, word_nx;

        len       = LW'(len_w);
        start     = 1'b1;
        adc_valid = 1'b0;
        wfull     = 1'b0;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);

        k = 0; acc = '0; words_done = 0; drops = 0;
        pend_now = 1'b0; final_now = 1'b0; pidx_now = 0; word_now = '0;
`ifdef ADC_PACK_HEADER_EN
        pend_now = 1'b1;
        word_now = DW'(fc);
        fc       = fc + 16'd1;
`endif
        j = 0; fin = 1'b0;
        while (!fin) begin
            case (fmode)
                0:       wfull = 1'b0;
                1:       wfull = 1'b1;
                2:       wfull = pend_now && (pidx_now == fword);
                default: wfull = ($urandom_range(0, 9) < 3);
            endcase
            if (pend_now) begin
                if (!wfull) sb.push_back('{w: word_now, c: cyc});
                else drops++;
            end
            fin = final_now;
            pend_next = 1'b0; final_next = 1'b0; pidx_next = 0; word_nx = '0;

            if (vmode == 0)      v = 1'b1;
            else if (vmode == 1) v = (j % 3 == 2);
            else                 v = ($urandom_range(0, 9) < 6);
            adc_valid = v;
            adc_data  = SW'($urandom);
            if (v && (words_done < len_w)) begin
                if (data_src.size() != 0) adc_data = data_src.pop_front();
                acc[k*SW +: SW] = adc_data;
                k++;
                if (k == PACK) begin
                    words_done++;
                    pend_next  = 1'b1;
                    word_nx    = acc;
                    pidx_next  = words_done;
                    final_next = (words_done == len_w);
                    acc = '0;
                    k   = 0;
                end
            end
            if (stress && ($urandom_range(0, 5) == 0)) begin
                start = 1'b1;
                len   = LW'($urandom_range(1, 40));
            end else begin
                start = 1'b0;
            end
            step();
            pend_now  = pend_next;
            final_now = final_next;
            pidx_now  = pidx_next;
            word_now  = word_nx;
            j++;
            if (j > 20000) begin
                chk("capture_bound", j, 0);
                fin = 1'b1;
            end
        end

        adc_valid = 1'b0;
        wfull     = 1'b0;
        chk("done_pulse", done, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        chk("ovf_cnt", ovf_cnt, (drops > 255) ? 255 : drops);
        if (stress) begin
            start = 1'b1;
            len   = LW'(5);
        end
        step();
        start = 1'b0;
        chk("done_one_cycle", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
        step();
        chk("busy_stays_idle", busy, 1'b0);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; fc = '0;
        wrst_n = 1'b0; start = 1'b0; len = '0;
        adc_valid = 1'b0; adc_data = '0; wfull = 1'b0;
        step();
        step();
        chk("rst_wr", wr, 1'b0);
        chk("rst_wdata", wdata, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", ovf_cnt, '0);
        wrst_n = 1'b1;
        step();

        // 1: valid every cycle, no backpressure
        for (int i = 1; i <= 6; i++) data_src.push_back(SW'(i));
        run_capture(3, 0, 0, 0, 1'b0);

        // 2: valid every third cycle
        for (int i = 1; i <= 6; i++) data_src.push_back(SW'(i));
        run_capture(3, 1, 0, 0, 1'b0);

        // 3: full only while word 2 pends
        for (int i = 1; i <= 6; i++) data_src.push_back(SW'(i));
        run_capture(3, 0, 2, 2, 1'b0);

        // 4: start while busy, and start with len == 0
        run_capture(4, 2, 0, 0, 1'b1);
        len   = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("len0_busy", busy, 1'b0);
        step();
        chk("len0_busy_later", busy, 1'b0);

        // 5: reset in the middle of a word
        len   = LW'(2);
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef ADC_PACK_HEADER_EN
        sb.push_back('{w: DW'(fc), c: cyc});
        fc = fc + 16'd1;
`endif
        adc_valid = 1'b1;
        adc_data  = 8'h55;
        step();
        adc_valid = 1'b0;
        #2;
        wrst_n = 1'b0;
        #1;
        chk("midrst_wr", wr, 1'b0);
        chk("midrst_wdata", wdata, '0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_ovf", ovf_cnt, '0);
        chk("midrst_sb_empty", sb.size(), 0);
        fc = '0;
        step();
        wrst_n = 1'b1;
        step();
        data_src.push_back(8'hAA);
        data_src.push_back(8'hBB);
        run_capture(1, 0, 0, 0, 1'b0);

        // 6: FIFO full for a long capture, counter saturates
        run_capture(300, 0, 1, 0, 1'b0);

        // randomized captures
        for (int n = 0; n < 25; n++) begin
            run_capture($urandom_range(1, 12), $urandom_range(0, 2),
                        ($urandom_range(0, 1) == 0) ? 0 : 3, 0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
